// File: rtl/ssd_scan_decoder_if.sv
// ssd_scan_decoder_if: scan inputs and decoded frame outputs of the scan decoder
interface ssd_scan_decoder_if;
  logic [3:0] anodes;
  logic [6:0] cathodes;
  logic [3:0] digit3;
  logic [3:0] digit2;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic frame_valid;
  logic seg_error;
  logic stale;
  modport master (
    output anodes, cathodes,
    input  digit3, digit2, digit1, digit0, frame_valid, seg_error, stale
  );
  modport slave (
    input  anodes, cathodes,
    output digit3, digit2, digit1, digit0, frame_valid, seg_error, stale
  );
endinterface

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: decodes a multiplexed seven-segment scan back into four-digit frames
module ssd_scan_decoder #(
  parameter int SETTLE = 4,
  parameter int TIMEOUT = 1048576
) (
  input logic clk_100M,
  input logic reset,
  ssd_scan_decoder_if.slave io_bus
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] C_MAX = CW'(SETTLE);
  localparam logic [CW-1:0] C_CAP = CW'(SETTLE - 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_PRE = TW'(TIMEOUT - 2);
  logic [3:0] r_prev_an;
  logic [6:0] r_prev_seg;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tcnt;
  logic [3:0] r_seen;
  logic [3:0] r_w [4];
  logic [3:0] r_dig [4];
  logic r_fv;
  logic r_err;
  logic r_stale;
  logic [3:0] w_code;
  logic [3:0] w_sel;
  logic [1:0] w_idx;
  logic w_legal;
  logic w_same;
  logic w_cap;
  logic w_done;
  // segment pattern to digit code; unknown patterns map to E
  always_comb begin
    case (io_bus.cathodes)
      7'b0000001: w_code = 4'h0;
      7'b1001111: w_code = 4'h1;
      7'b0010010: w_code = 4'h2;
      7'b0000110: w_code = 4'h3;
      7'b1001100: w_code = 4'h4;
      7'b0100100: w_code = 4'h5;
      7'b0100000: w_code = 4'h6;
      7'b0001111: w_code = 4'h7;
      7'b0000000: w_code = 4'h8;
      7'b0000100: w_code = 4'h9;
      7'b1111110: w_code = 4'hA;
      7'b1111111: w_code = 4'hF;
      default:    w_code = 4'hE;
    endcase
  end
  assign w_legal = io_bus.anodes inside {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  assign w_same  = io_bus.anodes == r_prev_an && io_bus.cathodes == r_prev_seg;
  assign w_cap   = w_same && w_legal && r_cnt == C_CAP;
  assign w_sel   = ~io_bus.anodes;
  assign w_idx   = io_bus.anodes == 4'b0111 ? 2'd3 :
                   io_bus.anodes == 4'b1011 ? 2'd2 :
                   io_bus.anodes == 4'b1101 ? 2'd1 : 2'd0;
  assign w_done  = (r_seen | w_sel) == 4'hF;
  // settle filter, digit capture, frame publish and staleness timer
  always_ff @(posedge clk_100M) begin
    if (reset) begin
      r_prev_an  <= 4'b1111;
      r_prev_seg <= 7'h7F;
      r_cnt      <= '0;
      r_tcnt     <= '0;
      r_seen     <= '0;
      r_w        <= '{default: 4'hF};
      r_dig      <= '{default: 4'hF};
      r_fv       <= 1'b0;
      r_err      <= 1'b0;
      r_stale    <= 1'b0;
    end else begin
      r_prev_an  <= io_bus.anodes;
      r_prev_seg <= io_bus.cathodes;
      r_cnt      <= (w_same && w_legal) ? (r_cnt == C_MAX ? C_MAX : r_cnt + 1'b1) : '0;
      r_fv       <= w_cap && w_done;
      if (w_cap) begin
        r_w[w_idx] <= w_code;
        r_seen     <= w_done ? 4'h0 : r_seen | w_sel;
        r_err      <= r_err || w_code == 4'hE;
      end
      if (w_cap && w_done) begin
        r_dig        <= r_w;
        r_dig[w_idx] <= w_code;
        r_tcnt       <= '0;
        r_stale      <= 1'b0;
      end else begin
        r_tcnt  <= r_tcnt == T_MAX ? T_MAX : r_tcnt + 1'b1;
        r_stale <= r_stale || r_tcnt >= T_PRE;
      end
    end
  end
  assign io_bus.digit3      = r_dig[3];
  assign io_bus.digit2      = r_dig[2];
  assign io_bus.digit1      = r_dig[1];
  assign io_bus.digit0      = r_dig[0];
  assign io_bus.frame_valid = r_fv;
  assign io_bus.seg_error   = r_err;
  assign io_bus.stale       = r_stale;
endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb_ssd_scan_decoder: directed scan sequences with a frame scoreboard
module tb_ssd_scan_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int n_frames = 0;
  logic fv_prev = 1'b0;
  logic [15:0] sb [$];
  ssd_scan_decoder_if bus ();
  ssd_scan_decoder #(.SETTLE(4), .TIMEOUT(64)) dut (
    .clk_100M(clk),
    .reset(reset),
    .io_bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] digits();
    return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
  endfunction
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic dwell(input logic [3:0] an, input logic [6:0] sg, input int n);
    bus.anodes = an;
    bus.cathodes = sg;
    repeat (n) @(negedge clk);
  endtask
  task automatic scan4(input logic [15:0] code);
    sb.push_back(code);
    dwell(4'b0111, seg_of(code[15:12]), 8);
    dwell(4'b1011, seg_of(code[11:8]), 8);
    dwell(4'b1101, seg_of(code[7:4]), 8);
    dwell(4'b1110, seg_of(code[3:0]), 8);
  endtask
  // frame scoreboard: every published frame must match the oldest expectation
  always @(negedge clk) begin
    if (frame_pulse_pair()) begin
      total++;
      bad++;
      $error("FAIL fv_back_to_back observed=11 expected=10");
    end
    if (bus.frame_valid === 1'b1) begin
      n_frames++;
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_frame observed=%h expected=none", digits());
      end
      if (sb.size() != 0) chk("frame", 32'(digits()), 32'(sb.pop_front()));
    end
    fv_prev = bus.frame_valid;
  end
  function automatic logic frame_pulse_pair();
    return fv_prev === 1'b1 && bus.frame_valid === 1'b1;
  endfunction
  initial begin
    bus.anodes = 4'b1111;
    bus.cathodes = 7'h7F;
    repeat (2) @(negedge clk);
    chk("rst_digits", 32'(digits()), 32'hFFFF);
    chk("rst_fv", 32'(bus.frame_valid), 32'd0);
    chk("rst_err", 32'(bus.seg_error), 32'd0);
    chk("rst_stale", 32'(bus.stale), 32'd0);
    reset = 1'b0;
    sb.push_back(16'h5163);
    dwell(4'b0111, seg_of(4'h5), 8);
    dwell(4'b1011, seg_of(4'h1), 8);
    dwell(4'b1101, seg_of(4'h6), 8);
    bus.anodes = 4'b1110;
    bus.cathodes = seg_of(4'h3);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("fv_timing_%0d", c), 32'(bus.frame_valid), 32'(c == 5));
    end
    chk("err_clean", 32'(bus.seg_error), 32'd0);
    dwell(4'b0111, seg_of(4'h7), 8);
    dwell(4'b1011, seg_of(4'h4), 4);
    dwell(4'b1101, seg_of(4'h9), 8);
    dwell(4'b1110, seg_of(4'h0), 8);
    chk("glitch_no_pub", 32'(n_frames), 32'd1);
    sb.push_back(16'h7290);
    dwell(4'b1011, seg_of(4'h2), 8);
    scan4(16'hFFA7);
    chk("sign_err", 32'(bus.seg_error), 32'd0);
    sb.push_back(16'h834E);
    dwell(4'b0111, seg_of(4'h8), 8);
    dwell(4'b1011, seg_of(4'h3), 8);
    dwell(4'b1101, seg_of(4'h4), 8);
    dwell(4'b1110, 7'b0110110, 8);
    chk("bad_err", 32'(bus.seg_error), 32'd1);
    scan4(16'h5163);
    chk("err_sticky", 32'(bus.seg_error), 32'd1);
    dwell(4'b1111, 7'h7F, 59);
    chk("stale_before", 32'(bus.stale), 32'd0);
    dwell(4'b1111, 7'h7F, 1);
    chk("stale_set", 32'(bus.stale), 32'd1);
    dwell(4'b1111, 7'h7F, 10);
    chk("stale_hold", 32'(bus.stale), 32'd1);
    chk("stale_digits", 32'(digits()), 32'h5163);
    sb.push_back(16'h1234);
    dwell(4'b0111, seg_of(4'h1), 8);
    dwell(4'b1011, seg_of(4'h2), 8);
    dwell(4'b1111, seg_of(4'h7), 10);
    dwell(4'b0011, seg_of(4'h7), 10);
    dwell(4'b1101, seg_of(4'h3), 8);
    dwell(4'b1110, seg_of(4'h4), 8);
    chk("stale_clear", 32'(bus.stale), 32'd0);
    dwell(4'b0111, seg_of(4'h1), 8);
    dwell(4'b1011, seg_of(4'h2), 8);
    reset = 1'b1;
    dwell(4'b1111, 7'h7F, 2);
    chk("midrst_digits", 32'(digits()), 32'hFFFF);
    chk("midrst_err", 32'(bus.seg_error), 32'd0);
    chk("midrst_fv", 32'(bus.frame_valid), 32'd0);
    reset = 1'b0;
    dwell(4'b1101, seg_of(4'h6), 8);
    dwell(4'b1110, seg_of(4'h8), 8);
    chk("midrst_no_pub", 32'(n_frames), 32'd6);
    sb.push_back(16'h9568);
    dwell(4'b0111, seg_of(4'h9), 8);
    dwell(4'b1011, seg_of(4'h5), 8);
    dwell(4'b1111, 7'h7F, 4);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("frames", 32'(n_frames), 32'd7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ssd_scan_decoder.md
# ssd_scan_decoder

Receive-side counterpart to the multiplexed seven-segment display drive. Samples the active-low anode-select and cathode buses produced by the display scan logic. Decodes each settled digit's segment pattern back to a 4-bit code and assembles a full four-digit frame. Used as an on-chip self-check monitor and as the scoreboard front-end in display testbenches.

## Interface
- `SETTLE`, default 4: cycles both buses must hold unchanged before a digit is captured (≥2).
- `TIMEOUT`, default 1048576: cycles without a completed frame before `stale` sets.
- `clk_100M` in 1: system clock. Single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `anodes` in 4: digit select, active-low one-hot.
  - `4'b0111` = digit3 (leftmost), `1011` = digit2, `1101` = digit1, `1110` = digit0.
- `cathodes` in 7: segments `{a,b,c,d,e,f,g}`, active-low.
- `digit3`, `digit2`, `digit1`, `digit0` out 4 each: last completed frame codes.
- `frame_valid` out 1: one-cycle pulse when a new frame is published.
- `seg_error` out 1: sticky; an unrecognised segment pattern was captured.
- `stale` out 1: no frame completed within `TIMEOUT` cycles.

## Operation
- Segment decode, combinational on `cathodes`:
  - `0000001`→0, `1001111`→1, `0010010`→2, `0000110`→3, `1001100`→4.
  - `0100100`→5, `0100000`→6, `0001111`→7, `0000000`→8, `0000100`→9.
  - `1111110` (minus)→`4'hA`; `1111111` (blank)→`4'hF`.
  - Any other pattern→`4'hE`, and flags an error on capture.
- Settle filter: registers `prev_an` and `prev_seg`, and counter `cnt` (saturates at `SETTLE`).
  - If `anodes != prev_an`, or `cathodes != prev_seg`, or `anodes` is not a legal one-hot-low value: `cnt`←0.
  - Otherwise `cnt`←min(`cnt`+1, `SETTLE`).
  - `prev_an`←`anodes` and `prev_seg`←`cathodes` every cycle.
- Capture: fires on the edge where the inputs equal prev, the anode value is legal, and `cnt == SETTLE-1`. At most one capture per dwell.
  - Decoded code is written into working register `w[i]` for the selected digit, and `seen[i]`←1.
  - Re-capturing a digit before frame completion overwrites it; the latest value wins.
  - A `4'hE` capture sets `seg_error`. It clears only on `reset`.
- Frame publish: on a capture edge where `seen | (1<<i) == 4'b1111`:
  - `digit3..0` load the working set, including the value being captured on this edge.
  - `frame_valid`←1 for exactly that cycle, and `seen`←0.
- Illegal anodes (`1111`, or multiple low): nothing is captured; `seen` and `w` are retained.
- Staleness: `tcnt` counts cycles since the last publish or since reset.
  - `stale` sets when `tcnt` reaches `TIMEOUT-1` and holds.
  - Publish clears `tcnt` and `stale` on the same edge. `digit*` retain their old values while stale.
- Reset, including mid-frame, overrides everything:
  - `digit*`=`4'hF`, `frame_valid`=0, `seg_error`=0, `stale`=0.
  - `seen`=0, `w`=`4'hF`, `cnt`=0, `tcnt`=0, `prev_an`=`4'b1111`, `prev_seg`=`7'h7F`.

## Timing
- Inputs are synchronous to `clk_100M`; no synchroniser.
- New stable value first sampled at edge N: `cnt`=0 at N, and the capture and `w` update occur at edge N+`SETTLE`.
- A dwell of ≤`SETTLE` cycles is never captured. Minimum capturing dwell is `SETTLE`+1 cycles.
- Publish latency: `digit*` and `frame_valid` update on the capture edge of the last missing digit. No extra pipeline stage.
- `frame_valid` is never high on two consecutive cycles, because that would require two captures one cycle apart.
- Scan order is irrelevant: any order that covers all four digits completes a frame.

## Test plan
- Reset: assert `reset` 2 cycles → `digit3..0`=F,F,F,F; `frame_valid`, `seg_error`, `stale` all 0.
- Scan "5163": dwell 8 cycles each on `0111`,`1011`,`1101`,`1110` → a single `frame_valid` pulse at the 4th dwell's first edge +4, with digits 5,1,6,3.
- Glitch: the `1011` dwell lasts only 4 cycles, then the scan continues → no publish. A later 8-cycle `1011` dwell of `0010010` publishes with digit2=2.
- Sign/blank: blank, blank, minus, then `0001111` → digits F,F,A,7; `seg_error` stays 0.
- Bad pattern `0110110` on digit0 during a full scan → digit0=E and `seg_error`=1. `seg_error` stays 1 through later clean frames until `reset`.
- Stale and reset: with `TIMEOUT`=64, hold `anodes`=`1111` for 70 cycles → `stale`=1 at cycle 63, digits unchanged; a full scan then clears `stale`. Asserting `reset` after 2 of 4 captures requires all four captures again before the next publish.
